seg7_scan_driver: RTL

- Output-side counterpart to the board input conditioning: drives a time-multiplexed, common-anode 7-segment display from a hex value held in internal registers.
- Paced by the shared `clock_enable` tick, the same one used by the input conditioners.
- New values are accepted through a load strobe and applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- A blanking gap between digits suppresses ghosting.

---
 rtl/seg7_scan_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-synchronous value updates.
// Optional decimal-point support is built when SEG7_DP_EN is defined.
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned DWELL_TICKS = 16,
    parameter int unsigned BLANK_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clock_enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     digit_en_in,
`ifdef SEG7_DP_EN
    input  logic [DIGITS-1:0]     dp_in,
    output logic                  dp_n,
`endif
    output logic [DIGITS-1:0]     anode_n,
    output logic [6:0]            seg_n,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntMax     = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
    localparam int unsigned CntW       = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned BlankLastI = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_TICKS - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BlankLastI);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e                state_q;
    logic [IdxW-1:0]       idx_q;
    logic [CntW-1:0]       tick_q;
    logic [4*DIGITS-1:0]   shadow_data_q, active_data_q;
    logic [DIGITS-1:0]     shadow_en_q, active_en_q;
`ifdef SEG7_DP_EN
    logic [DIGITS-1:0]     shadow_dp_q, active_dp_q;
`endif

    logic       dwell_end;
    logic       wrap;
    logic [3:0] cur_nib;
    logic [6:0] cur_seg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        dwell_end = (state_q == StShow) && clock_enable && (tick_q == DwellLast);
        wrap      = dwell_end && (idx_q == IdxLast);
        cur_nib   = active_data_q[{idx_q, 2'b00} +: 4];
        cur_seg   = hex7(cur_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBlank;
            idx_q         <= '0;
            tick_q        <= '0;
            shadow_data_q <= '0;
            active_data_q <= '0;
            shadow_en_q   <= '1;
            active_en_q   <= '1;
            anode_n       <= '1;
            seg_n         <= 7'h7F;
            frame_done    <= 1'b0;
            pending       <= 1'b0;
`ifdef SEG7_DP_EN
            shadow_dp_q   <= '0;
            active_dp_q   <= '0;
            dp_n          <= 1'b1;
`endif
        end else begin
            // Outputs follow the current state, so they lag each transition by one clk.
            anode_n    <= '1;
            seg_n      <= 7'h7F;
            frame_done <= wrap;
`ifdef SEG7_DP_EN
            dp_n       <= 1'b1;
`endif
            if (state_q == StShow) begin
                anode_n[idx_q] <= ~active_en_q[idx_q];
                seg_n          <= ~cur_seg;
`ifdef SEG7_DP_EN
                dp_n           <= ~(active_dp_q[idx_q] & active_en_q[idx_q]);
`endif
            end

            if (load) begin
                shadow_data_q <= data_in;
                shadow_en_q   <= digit_en_in;
`ifdef SEG7_DP_EN
                shadow_dp_q   <= dp_in;
`endif
                pending       <= 1'b1;
            end

            unique case (state_q)
                StBlank: begin
                    if (BLANK_TICKS == 0) begin
                        state_q <= StShow;
                    end else if (clock_enable) begin
                        if (tick_q == BlankLast) begin
                            state_q <= StShow;
                            tick_q  <= '0;
                        end else begin
                            tick_q <= tick_q + CntW'(1);
                        end
                    end
                end
                StShow: begin
                    if (dwell_end) begin
                        state_q <= StBlank;
                        tick_q  <= '0;
                        idx_q   <= wrap ? '0 : idx_q + IdxW'(1);
                    end else if (clock_enable) begin
                        tick_q <= tick_q + CntW'(1);
                    end
                end
                default: state_q <= StBlank;
            endcase

            // A load on the wrap edge bypasses the shadow so it is not delayed a frame.
            if (wrap) begin
                if (load) begin
                    active_data_q <= data_in;
                    active_en_q   <= digit_en_in;
`ifdef SEG7_DP_EN
                    active_dp_q   <= dp_in;
`endif
                    pending       <= 1'b0;
                end else if (pending) begin
                    active_data_q <= shadow_data_q;
                    active_en_q   <= shadow_en_q;
`ifdef SEG7_DP_EN
                    active_dp_q   <= shadow_dp_q;
`endif
                    pending       <= 1'b0;
                end
            end
        end
    end

endmodule
